// File: rtl/cap_sense_if.sv
// Signal bundle between the capacitive sensor pins, software GPIO and the touch front end.
interface cap_sense_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
);
    logic [CHANNELS-1:0]       sensor_receive;
    logic [CHANNELS-1:0]       sensor_send;
    logic [CHANNELS-1:0]       event_clear;
    logic [CHANNELS-1:0]       raw_touch;
    logic [CHANNELS-1:0]       touch;
    logic [CHANNELS-1:0]       sample_valid;
    logic [CHANNELS-1:0]       event_sticky;
    logic [CHANNELS*CNT_W-1:0] charge_count;

    modport master (
        output sensor_receive, event_clear,
        input  sensor_send, raw_touch, touch, sample_valid, event_sticky, charge_count
    );

    modport slave (
        input  sensor_receive, event_clear,
        output sensor_send, raw_touch, touch, sample_valid, event_sticky, charge_count
    );
endinterface

// File: rtl/cap_sense_array.sv
// Multi-channel capacitive touch front end: each channel times how long its sensor
// takes to charge, decides touched/untouched, stretches touch and keeps a sticky event.
module cap_sense_chan #(
    parameter int CNT_W       = 16,
    parameter int THRESHOLD   = 25000,
    parameter int DELAY       = 3000,
    parameter int HOLD_CYCLES = 2500000,
    parameter int HOLD_W      = 22
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sensor_receive,
    input  logic             event_clear,
    output logic             sensor_send,
    output logic             raw_touch,
    output logic             touch,
    output logic             sample_valid,
    output logic             event_sticky,
    output logic [CNT_W-1:0] charge_count
);
    typedef enum logic {DISCHARGE, CHARGE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt, count_nxt;
    logic [1:0]          rx_pipe;
    logic                rx_s;
    logic                finish, raw_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                touch_d;

    assign rx_s  = rx_pipe[1];
    assign touch = raw_touch | (hold_cnt != '0);

    // Terminal compares come before the increment, so cnt never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        count_nxt = cnt;
        finish    = 1'b0;
        raw_nxt   = 1'b0;
        case (state)
            DISCHARGE: begin
                if (cnt == CNT_W'(DELAY - 1)) begin
                    state_nxt = CHARGE;
                    cnt_nxt   = '0;
                end
            end
            CHARGE: begin
                if (rx_s) begin
                    finish    = 1'b1;
                    state_nxt = DISCHARGE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(THRESHOLD - 1)) begin
                    finish    = 1'b1;
                    raw_nxt   = 1'b1;
                    count_nxt = CNT_W'(THRESHOLD);
                    state_nxt = DISCHARGE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = DISCHARGE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= DISCHARGE;
            cnt          <= '0;
            rx_pipe      <= '0;
            sensor_send  <= 1'b0;
            sample_valid <= 1'b0;
            charge_count <= '0;
            raw_touch    <= 1'b0;
            hold_cnt     <= '0;
            touch_d      <= 1'b0;
            event_sticky <= 1'b0;
        end else begin
            rx_pipe      <= {rx_pipe[0], sensor_receive};
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            sensor_send  <= (state_nxt == CHARGE);
            sample_valid <= finish;
            if (finish) begin
                charge_count <= count_nxt;
                raw_touch    <= raw_nxt;
            end
            // Hold only runs down once the raw decision has gone low.
            if (finish && raw_nxt)
                hold_cnt <= HOLD_W'(HOLD_CYCLES);
            else if (!raw_touch && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            touch_d      <= touch;
            event_sticky <= (touch & ~touch_d) | (event_sticky & ~event_clear);
        end
    end
endmodule

module cap_sense_array #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int THRESHOLD   = 25000,
    parameter int DELAY       = 3000,
    parameter int HOLD_CYCLES = 2500000,
    parameter int HOLD_W      = 22
) (
    input  logic        clock,
    input  logic        reset,
    cap_sense_if.slave  bus
);
    logic [CHANNELS-1:0]            send_a, raw_a, touch_a, valid_a, sticky_a;
    logic [CHANNELS-1:0][CNT_W-1:0] count_a;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cap_sense_chan #(
            .CNT_W      (CNT_W),
            .THRESHOLD  (THRESHOLD),
            .DELAY      (DELAY),
            .HOLD_CYCLES(HOLD_CYCLES),
            .HOLD_W     (HOLD_W)
        ) u_ch (
            .clock         (clock),
            .reset         (reset),
            .sensor_receive(bus.sensor_receive[i]),
            .event_clear   (bus.event_clear[i]),
            .sensor_send   (send_a[i]),
            .raw_touch     (raw_a[i]),
            .touch         (touch_a[i]),
            .sample_valid  (valid_a[i]),
            .event_sticky  (sticky_a[i]),
            .charge_count  (count_a[i])
        );
    end

    assign bus.sensor_send  = send_a;
    assign bus.raw_touch    = raw_a;
    assign bus.touch        = touch_a;
    assign bus.sample_valid = valid_a;
    assign bus.event_sticky = sticky_a;
    assign bus.charge_count = count_a;
endmodule
